a2owb_arb: RTL and testbench

- Round-robin Wishbone arbiter sharing the single a2owb master port (wb_*) between NUM_M requesters, e.g. core fetch/LSU bridge and debug/config master.
- Sits between the requesters and the SoC Wishbone slave.
- Holds the grant for a whole cycle (wb_cyc) so block transfers are not interleaved.
- A bus watchdog terminates stalled slave accesses with an error and counts them.

---
 rtl/a2owb_arb_if.sv | 34 +++
 rtl/a2owb_arb.sv | 120 ++++++++++++
 tb/tb_a2owb_arb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/a2owb_arb_if.sv
// Bus bundle between the a2owb arbiter, its requesting masters and the shared Wishbone slave.
// The arbiter uses the master modport (it masters the wb_* side); the environment uses slave.
interface a2owb_arb_if #(
    parameter int NUM_M = 2
);
    logic [NUM_M-1:0]    m_cyc;
    logic [NUM_M-1:0]    m_stb;
    logic [NUM_M-1:0]    m_we;
    logic [32*NUM_M-1:0] m_adr;
    logic [4*NUM_M-1:0]  m_sel;
    logic [32*NUM_M-1:0] m_datw;
    logic [NUM_M-1:0]    m_ack;
    logic [NUM_M-1:0]    m_err;
    logic [31:0]         m_datr;

    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [31:0]         wb_adr;
    logic [3:0]          wb_sel;
    logic [31:0]         wb_datw;
    logic                wb_ack;
    logic [31:0]         wb_datr;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_datw, wb_ack, wb_datr,
        output m_ack, m_err, m_datr, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_datw
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_datw, wb_ack, wb_datr,
        input  m_ack, m_err, m_datr, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_datw
    );
endinterface

// File: rtl/a2owb_arb.sv
// Round-robin Wishbone arbiter: grants the shared wb_* port to one requester for a whole
// wb_cyc, and a watchdog aborts strobes the slave never acknowledges.
module a2owb_arb #(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_1x,
    input  logic        rst,
    a2owb_arb_if.master bus,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        TERM = 2'd2
    } state_e;

    localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] wd_q, wd_d;
    logic [7:0]  tocnt_q, tocnt_d;
    logic        found;
    int          pickIdx;

    always_ff @(posedge clk_1x) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
            ptr_q   <= 2'd0;
            wd_q    <= 16'd0;
            tocnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            tocnt_q <= tocnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        wd_d         = wd_q;
        tocnt_d      = tocnt_q;
        found        = 1'b0;
        pickIdx      = 0;
        bus.wb_cyc   = 1'b0;
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_adr   = 32'd0;
        bus.wb_sel   = 4'd0;
        bus.wb_datw  = 32'd0;
        bus.m_ack    = '0;
        bus.m_err    = '0;

        case (state_q)
            IDLE: begin
                wd_d = 16'd0;
                // Search starts at ptr so the most recently served master goes last.
                for (int i = 0; i < NUM_M; i++) begin
                    pickIdx = (int'(ptr_q) + i) % NUM_M;
                    if (!found && bus.m_cyc[pickIdx]) begin
                        found   = 1'b1;
                        gnt_d   = 2'(pickIdx);
                        ptr_d   = 2'((pickIdx + 1) % NUM_M);
                        state_d = BUS;
                    end
                end
            end

            BUS: begin
                bus.wb_cyc         = bus.m_cyc[gnt_q];
                bus.wb_stb         = bus.m_stb[gnt_q];
                bus.wb_we          = bus.m_we[gnt_q];
                bus.wb_adr         = bus.m_adr[32*int'(gnt_q) +: 32];
                bus.wb_sel         = bus.m_sel[4*int'(gnt_q) +: 4];
                bus.wb_datw        = bus.m_datw[32*int'(gnt_q) +: 32];
                bus.m_ack[gnt_q]   = bus.wb_ack & bus.m_stb[gnt_q];

                if (!bus.m_cyc[gnt_q]) begin
                    state_d = IDLE;
                    wd_d    = 16'd0;
                end else if (bus.m_stb[gnt_q] && !bus.wb_ack) begin
                    // An ack in the expiry cycle takes the other branch, so ack always wins.
                    if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                        bus.m_err[gnt_q] = 1'b1;
                        tocnt_d          = (tocnt_q == 8'hFF) ? tocnt_q : tocnt_q + 8'd1;
                        wd_d             = 16'd0;
                        state_d          = TERM;
                    end else begin
                        wd_d = (TIMEOUT != 0) ? wd_q + 16'd1 : 16'd0;
                    end
                end else begin
                    wd_d = 16'd0;
                end
            end

            TERM: begin
                if (!bus.m_cyc[gnt_q]) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_datr = bus.wb_datr;

    assign status = {(state_q != IDLE), 5'd0, gnt_q, 8'd0, 6'd0, ptr_q, tocnt_q};

endmodule

// File: tb/tb_a2owb_arb.sv
// Self-checking bench for a2owb_arb: single transfer, round-robin alternation, burst hold,
// watchdog expiry, ack-on-expiry and mid-cycle reset, with a scoreboard of expected acks.
module tb_a2owb_arb;

    localparam int NUM_M   = 2;
    localparam int TIMEOUT = 8;

    logic        clk_1x = 1'b0;
    logic        rst;
    logic [31:0] status;

    a2owb_arb_if #(.NUM_M(NUM_M)) busIf ();

    a2owb_arb #(
        .NUM_M   (NUM_M),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_1x (clk_1x),
        .rst    (rst),
        .bus    (busIf.master),
        .status (status)
    );

    always #5 clk_1x = ~clk_1x;

    typedef struct {
        int          master;
        logic [31:0] adr;
        logic [31:0] data;
    } txn_t;

    txn_t        expQ[$];
    int          checkCount = 0;
    int          failCount  = 0;
    int          expTocnt   = 0;
    logic [31:0] mAdr [NUM_M];

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_1x);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] datw);
        busIf.m_cyc[m]            = cyc;
        busIf.m_stb[m]            = stb;
        busIf.m_we[m]             = we;
        busIf.m_adr[32*m +: 32]   = adr;
        busIf.m_sel[4*m +: 4]     = 4'hF;
        busIf.m_datw[32*m +: 32]  = datw;
        #1;
    endtask

    // Slave acknowledges this cycle; the oldest expected transaction must be the one acked.
    task automatic ackBeat(input logic [31:0] data);
        txn_t e;
        busIf.wb_ack  = 1'b1;
        busIf.wb_datr = data;
        #1;
        if (expQ.size() == 0) begin
            checkOutput("sbUnderflow", 64'd1, 64'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("ackVec",  64'(busIf.m_ack),  64'(1 << e.master));
            checkOutput("ackDatr", 64'(busIf.m_datr), 64'(e.data));
            checkOutput("ackAdr",  64'(busIf.wb_adr), 64'(e.adr));
            checkOutput("ackErr",  64'(busIf.m_err),  64'd0);
        end
    endtask

    task automatic slaveIdle();
        busIf.wb_ack  = 1'b0;
        busIf.wb_datr = 32'd0;
        #1;
    endtask

    task automatic waitGrant(input int expGnt, input int budget);
        int n = 0;
        while (busIf.wb_cyc !== 1'b1 && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("grantSeen", 64'(busIf.wb_cyc), 64'd1);
        checkOutput("grantIdx",  64'(status[25:24]), 64'(expGnt));
    endtask

    task automatic doReset();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst           = 1'b1;
        busIf.m_cyc   = '0;
        busIf.m_stb   = '0;
        busIf.m_we    = '0;
        busIf.m_adr   = '0;
        busIf.m_sel   = '0;
        busIf.m_datw  = '0;
        busIf.wb_ack  = 1'b0;
        busIf.wb_datr = 32'd0;

        doReset();
        checkOutput("rstWbCyc",  64'(busIf.wb_cyc), 64'd0);
        checkOutput("rstWbStb",  64'(busIf.wb_stb), 64'd0);
        checkOutput("rstWbAdr",  64'(busIf.wb_adr), 64'd0);
        checkOutput("rstAck",    64'(busIf.m_ack),  64'd0);
        checkOutput("rstErr",    64'(busIf.m_err),  64'd0);
        checkOutput("rstStatus", 64'(status),       64'd0);

        // Single read from master 0.
        expQ.push_back('{0, 32'h0000_1000, 32'hDEAD_BEEF});
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'd0);
        checkOutput("t1NoGrantYet", 64'(busIf.wb_cyc), 64'd0);
        stepCycle();
        checkOutput("t1Cyc",    64'(busIf.wb_cyc), 64'd1);
        checkOutput("t1Adr",    64'(busIf.wb_adr), 64'h0000_1000);
        checkOutput("t1Status", 64'(status),       64'h8000_0100);
        ackBeat(32'hDEAD_BEEF);
        stepCycle();
        slaveIdle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'd0);
        stepCycle();
        checkOutput("t1Idle", 64'(status[31]), 64'd0);

        // Both masters request continuously: grants alternate starting at 0.
        doReset();
        mAdr[0] = 32'h0000_2000;
        mAdr[1] = 32'h0000_3000;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, mAdr[0], 32'd0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, mAdr[1], 32'd0);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            expQ.push_back('{g, mAdr[g], 32'hA000_0000 + 32'(k)});
            waitGrant(g, 6);
            ackBeat(32'hA000_0000 + 32'(k));
            stepCycle();
            slaveIdle();
            applyStimulus(g, 1'b0, 1'b0, 1'b0, mAdr[g], 32'd0);
            stepCycle();
            checkOutput("t2DeadValid", 64'(status[31]),   64'd0);
            checkOutput("t2DeadWbCyc", 64'(busIf.wb_cyc), 64'd0);
            applyStimulus(g, 1'b1, 1'b1, 1'b0, mAdr[g], 32'd0);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, mAdr[0], 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, mAdr[1], 32'd0);

        // Master 1 holds cyc through a 4-beat write burst while master 0 waits.
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h5555_5555);
        stepCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'd0);
        checkOutput("t3Gnt",  64'(status[25:24]), 64'd1);
        checkOutput("t3We",   64'(busIf.wb_we),   64'd1);
        checkOutput("t3Datw", 64'(busIf.wb_datw), 64'h5555_5555);
        for (int b = 0; b < 4; b++) begin
            expQ.push_back('{1, 32'h0000_4000 + 32'(4*b), 32'hB000_0000 + 32'(b)});
            applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_4000 + 32'(4*b), 32'h5555_5555);
            ackBeat(32'hB000_0000 + 32'(b));
            stepCycle();
            checkOutput("t3HoldGnt", 64'(status[25:24]), 64'd1);
        end
        slaveIdle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'd0);
        expQ.push_back('{0, 32'h0000_6000, 32'h0000_C0DE});
        waitGrant(0, 6);
        ackBeat(32'h0000_C0DE);
        stepCycle();
        slaveIdle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'd0);
        stepCycle();

        // Slave never acks: error pulse on the TIMEOUT-th strobe cycle.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'd0);
        stepCycle();
        for (int c = 1; c < TIMEOUT; c++) begin
            checkOutput("t4NoErrEarly", 64'(busIf.m_err), 64'd0);
            stepCycle();
        end
        checkOutput("t4ErrPulse", 64'(busIf.m_err), 64'd1);
        checkOutput("t4NoAck",    64'(busIf.m_ack), 64'd0);
        expTocnt++;
        stepCycle();
        checkOutput("t4TermCyc", 64'(busIf.wb_cyc), 64'd0);
        checkOutput("t4TermStb", 64'(busIf.wb_stb), 64'd0);
        checkOutput("t4ErrOnce", 64'(busIf.m_err),  64'd0);
        checkOutput("t4Tocnt",   64'(status[7:0]),  64'(expTocnt));
        busIf.wb_ack = 1'b1;
        #1;
        checkOutput("t4LateAck", 64'(busIf.m_ack), 64'd0);
        slaveIdle();
        stepCycle();
        checkOutput("t4HoldTerm", 64'(status[31]), 64'd1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'd0);
        stepCycle();
        checkOutput("t4Idle", 64'(status[31]), 64'd0);

        // Ack lands exactly on the expiry cycle, then reset in the middle of the cycle.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'd0);
        stepCycle();
        for (int c = 1; c < TIMEOUT; c++) begin
            stepCycle();
        end
        expQ.push_back('{0, 32'h0000_8000, 32'h0000_FACE});
        ackBeat(32'h0000_FACE);
        stepCycle();
        slaveIdle();
        checkOutput("t5Tocnt",    64'(status[7:0]),   64'(expTocnt));
        checkOutput("t5StillBus", 64'(busIf.wb_cyc),  64'd1);
        rst = 1'b1;
        stepCycle();
        checkOutput("t5RstCyc",    64'(busIf.wb_cyc),              64'd0);
        checkOutput("t5RstStatus", 64'(status),                    64'd0);
        checkOutput("t5RstAckErr", 64'(busIf.m_ack | busIf.m_err), 64'd0);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 32'd0);

        checkOutput("sbEmpty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
